// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing a single memory port: data has priority, fetch
// gets a guaranteed slot after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned WW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] starve_cnt, starve_cnt_d;
  logic [WW-1:0] wait_cnt, wait_cnt_d;
  logic          mem_req_d, mem_we_d, owner_d, busy_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
  logic [SW-1:0] mem_wstrb_d;
  logic          if_ack_d, if_err_d, dm_ack_d, dm_err_d;
  logic          grant_fetch;

  // State and every output are registered; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      if_rdata   <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      dm_rdata   <= '0;
      dm_ack     <= 1'b0;
      dm_err     <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_cnt_d;
      wait_cnt   <= wait_cnt_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_wstrb  <= mem_wstrb_d;
      if_rdata   <= if_rdata_d;
      if_ack     <= if_ack_d;
      if_err     <= if_err_d;
      dm_rdata   <= dm_rdata_d;
      dm_ack     <= dm_ack_d;
      dm_err     <= dm_err_d;
      busy       <= busy_d;
      owner      <= owner_d;
    end
  end

  // Next-state and next-output logic; acks and errs default low, data holds.
  always_comb begin
    state_d      = state;
    starve_cnt_d = starve_cnt;
    wait_cnt_d   = wait_cnt;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_wstrb_d  = mem_wstrb;
    if_rdata_d   = if_rdata;
    dm_rdata_d   = dm_rdata;
    if_ack_d     = 1'b0;
    if_err_d     = 1'b0;
    dm_ack_d     = 1'b0;
    dm_err_d     = 1'b0;
    owner_d      = owner;
    grant_fetch  = if_req && (!dm_req || (starve_cnt == CW'(STARVE_LIMIT)));

    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d    = ISSUE;
          mem_req_d  = 1'b1;
          wait_cnt_d = '0;
          if (grant_fetch) begin
            owner_d      = 1'b0;
            mem_we_d     = 1'b0;
            mem_addr_d   = if_addr;
            mem_wdata_d  = '0;
            mem_wstrb_d  = '0;
            starve_cnt_d = '0;
          end else begin
            owner_d      = 1'b1;
            mem_we_d     = dm_we;
            mem_addr_d   = dm_addr;
            mem_wdata_d  = dm_wdata;
            mem_wstrb_d  = dm_wstrb;
            starve_cnt_d = if_req ? starve_cnt + CW'(1) : '0;
          end
        end
      end
      ISSUE: begin
        // A response in the timeout cycle still wins over the error.
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (owner) begin
            dm_rdata_d = mem_rdata;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
        end else if (wait_cnt + WW'(1) == WW'(TIMEOUT)) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (owner) begin
            dm_rdata_d = '0;
            dm_ack_d   = 1'b1;
            dm_err_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
            if_err_d   = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt + WW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data grants allowed while a fetch waits (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning max ISSUE cycles without mem_ack before an error response (legal 2..255).
REQ-003 SHALL have port clk  in  1  single clock, rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports if_req in 1, if_addr in 32: fetch read request and word address.
REQ-006 SHALL have ports if_rdata out 32, if_ack out 1, if_err out 1: fetch response.
REQ-007 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in 32, dm_wdata in 32, dm_wstrb in 4: data request.
REQ-008 SHALL have ports dm_rdata out 32, dm_ack out 1, dm_err out 1: data response.
REQ-009 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4: shared memory port.
REQ-010 SHALL have ports mem_rdata in 32, mem_ack in 1: memory response.
REQ-011 SHALL have ports busy out 1 (state != IDLE) and owner out 1 (0 = fetch, 1 = data; current/last grant).

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; all outputs registered.
REQ-013 SHALL sample if_req/dm_req only in IDLE; with neither asserted, remain in IDLE.
REQ-014 SHALL grant data over fetch, except grant fetch when if_req=1 and starve count == STARVE_LIMIT.
REQ-015 SHALL increment 4-bit starve count on a data grant while if_req=1; clear it on a fetch grant or on a data grant with if_req=0.
REQ-016 SHALL, on grant, latch address/we/wdata/wstrb (fetch: we=0, wstrb=0) and enter ISSUE, asserting mem_req and the latched fields from the next cycle.
REQ-017 SHALL hold mem_req and all mem_* fields stable in ISSUE until mem_ack=1 is sampled.
REQ-018 SHALL, on mem_ack in ISSUE, deassert mem_req, capture mem_rdata into the granted requester's rdata, and enter RESP.
REQ-019 SHALL assert the granted requester's ack for exactly the one RESP cycle; the other requester's ack stays 0.
REQ-020 SHALL give minimum latency: req in IDLE at cycle 0, mem_req cycles 1.., zero-wait mem_ack at cycle 1 -> ack at cycle 2, IDLE at cycle 3.
REQ-021 SHALL require the requester to hold req and fields until ack; a req still high in the IDLE after RESP is a new request.
REQ-022 SHALL count ISSUE cycles in an 8-bit wait counter, cleared on ISSUE entry.
REQ-023 SHALL, when wait counter reaches TIMEOUT without mem_ack, deassert mem_req, enter RESP with err=1 and rdata=0.
REQ-024 SHALL give mem_ack priority over timeout when both occur in the same cycle (err=0, data captured).
REQ-025 SHALL ignore mem_ack outside ISSUE.
REQ-026 SHALL hold rdata values between responses; err is valid only with ack and is 0 otherwise.

Reset
REQ-027 SHALL, with rst=0 at a rising edge, enter IDLE and zero every output, starve count, wait counter and latched field, regardless of state.
REQ-028 SHALL, on reset during ISSUE, drop mem_req at that edge and issue no ack for the aborted request.
REQ-029 SHALL, after reset release, accept requests from the first IDLE cycle.

Verification
REQ-030 Fetch alone, if_addr=0x100, mem_ack 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, if_rdata=0xDEADBEEF, if_ack one cycle, if_err=0.
REQ-031 if_req and dm_req same cycle, zero-wait memory -> data serviced first (owner=1), then fetch (owner=0) starting the IDLE after dm_ack.
REQ-032 dm_req held continuously with if_req=1, STARVE_LIMIT=4 -> exactly 4 data grants, then one fetch grant, then data resumes.
REQ-033 Data write dm_we=1, dm_addr=0x2000, dm_wdata=0xA5A5_1234, dm_wstrb=4'b0011 -> identical mem_* fields, held until mem_ack, dm_ack one cycle.
REQ-034 TIMEOUT=8, mem_ack never asserted -> mem_req high 8 cycles then low, dm_ack=1 with dm_err=1, dm_rdata=0.
REQ-035 rst=0 mid-ISSUE then late mem_ack after release -> mem_req drops, no ack, late mem_ack ignored, next request serviced normally.
